// File: rtl/mem_bus_if_if.sv
// Memory-side bus of the multicycle core: request/ack handshake with address,
// write data and returned read data.
interface mem_bus_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_adr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_bus_if.sv
// Single-outstanding memory access engine between the multicycle core and a
// variable-latency memory, with a timeout abort and a BUSY-cycle counter.
//
// state | meaning
// IDLE  | waiting for core_req; request fields captured on entry to BUSY
// BUSY  | mem_req held from captured fields until ack or timeout
// DONE  | one-cycle core_done pulse, then back to IDLE
module mem_bus_if #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 'h13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rdata,
  output logic              bus_err,
  output logic [31:0]       wait_cycles,
  mem_bus_if_if.master      mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       expired;

  // A timeout first drops mem_req in BUSY cycle TIMEOUT, then spends one more
  // BUSY cycle with the request withdrawn before reporting the abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      expired       <= 1'b0;
      core_done     <= 1'b0;
      core_rdata    <= '0;
      bus_err       <= 1'b0;
      wait_cycles   <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_adr   <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          core_done <= 1'b0;
          if (core_req) begin
            mem.mem_we    <= core_we;
            mem.mem_adr   <= core_adr;
            mem.mem_wdata <= core_wdata;
            mem.mem_req   <= 1'b1;
            tmo_cnt       <= '0;
            expired       <= 1'b0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cycles != 32'hFFFF_FFFF) wait_cycles <= wait_cycles + 32'd1;
          if (expired) begin
            bus_err   <= 1'b1;
            if (!mem.mem_we) core_rdata <= ERR_DATA;
            core_done <= 1'b1;
            state     <= DONE;
          end else if (mem.mem_ack) begin
            if (!mem.mem_we) core_rdata <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            core_done   <= 1'b1;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_cnt == 8'(TIMEOUT - 1)) begin
              expired     <= 1'b1;
              mem.mem_req <= 1'b0;
            end
          end
        end
        DONE: begin
          core_done <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem.mem_req <= 1'b0;
          core_done   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: table of accesses against a behavioural memory, with
// a scoreboard of expected completions plus idle-ack and mid-BUSY reset cases.
module tb_mem_bus_if;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_adr, core_wdata;
  logic        core_done, bus_err;
  logic [31:0] core_rdata, wait_cycles;

  mem_bus_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .ERR_DATA(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
    .core_done(core_done), .core_rdata(core_rdata), .bus_err(bus_err),
    .wait_cycles(wait_cycles), .mem(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdata;
    int          nwait;
    logic [31:0] rdata;
    bit          noack;
    bit          keep;
  } vec_t;

  typedef struct {
    int          cyc;
    int          req_cycles;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] waits;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_rdata = '0;
  bit          m_err = 0;
  logic [31:0] m_wait = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v);
    exp_t e, got_e;
    int   cyc, busy;
    bit   got;
    e.cyc        = v.noack ? TMO + 2 : v.nwait + 2;
    e.req_cycles = v.noack ? TMO : v.nwait + 1;
    if (!v.we) m_rdata = v.noack ? 32'h0000_0013 : v.rdata;
    if (v.noack) m_err = 1;
    m_wait += v.noack ? TMO + 1 : v.nwait + 1;
    e.rdata = m_rdata;
    e.err   = m_err;
    e.waits = m_wait;
    sb.push_back(e);

    @(posedge clk); #1;
    core_req = 1; core_we = v.we; core_adr = v.adr; core_wdata = v.wdata;
    cyc = 0; busy = 0; got = 0;
    while (!got && cyc < 300) begin
      @(posedge clk); cyc++;
      if (cyc == 2) begin
        #1; core_we = ~v.we; core_adr = ~v.adr; core_wdata = ~v.wdata;
      end
      @(negedge clk);
      if (v.noack && cyc == TMO + 1) chk("err_before_abort", bus_err, e.err && !v.noack ? 1 : (sb.size() > 0 ? 64'(m_err & ~v.noack) : 0));
      if (bus.mem_req) begin
        busy++;
        chk("mem_we", bus.mem_we, v.we);
        chk("mem_adr", bus.mem_adr, v.adr);
        chk("mem_wdata", bus.mem_wdata, v.wdata);
        if (!v.noack && busy == v.nwait + 1) begin
          bus.mem_ack = 1; bus.mem_rdata = v.rdata;
        end else begin
          bus.mem_ack = 0; bus.mem_rdata = $urandom;
        end
      end else begin
        bus.mem_ack = 0;
      end
      if (core_done) begin
        got = 1;
        if (v.keep) begin
          core_adr = 32'h0; core_we = 0;
        end else begin
          core_req = 0;
        end
      end
    end
    chk("done_seen", got, 1);
    got_e = sb.pop_front();
    chk("done_cycle", cyc, got_e.cyc);
    chk("req_cycles", busy, got_e.req_cycles);
    chk("core_rdata", core_rdata, got_e.rdata);
    chk("bus_err", bus_err, got_e.err);
    chk("wait_cycles", wait_cycles, got_e.waits);
    if (!v.keep) begin
      @(posedge clk); @(negedge clk);
      chk("done_one_cycle", core_done, 0);
    end
  endtask

  vec_t vecs[8];
  int   pulses;

  initial begin
    vecs[0] = '{0, 32'h100,  32'h0,        0, 32'h0050_0093, 0, 0};
    vecs[1] = '{1, 32'h2004, 32'hCAFE_F00D, 3, 32'h0,         0, 0};
    vecs[2] = '{0, 32'h300,  32'h0,        3, 32'hDEAD_BEEF, 0, 0};
    vecs[3] = '{0, 32'h40,   32'h0,        1, 32'h1234_5678, 0, 1};
    vecs[4] = '{0, 32'h0,    32'h0,        0, 32'h0000_A0B7, 0, 0};
    vecs[5] = '{0, 32'h80,   32'h0,        0, 32'h7777_7777, 1, 0};
    vecs[6] = '{1, 32'h44,   32'h1111_2222, 0, 32'h0,         0, 0};
    vecs[7] = '{0, 32'h8,    32'h0,        2, 32'hA5A5_0001, 0, 0};

    reset = 1; core_req = 0; core_we = 0; core_adr = '0; core_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_adr", bus.mem_adr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_core_done", core_done, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_wait_cycles", wait_cycles, 0);

    for (int i = 0; i < 8; i++) do_access(vecs[i]);

    // Acknowledge pulse while idle must be ignored.
    @(negedge clk);
    bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    bus.mem_ack = 0;
    chk("idle_ack_rdata", core_rdata, m_rdata);
    chk("idle_ack_done", core_done, 0);
    chk("idle_ack_req", bus.mem_req, 0);
    chk("idle_ack_wait", wait_cycles, m_wait);
    @(posedge clk); @(negedge clk);
    chk("idle_ack_req2", bus.mem_req, 0);

    // Reset during the second BUSY cycle abandons the access.
    @(posedge clk); #1;
    core_req = 1; core_we = 0; core_adr = 32'h500;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("pre_reset_req", bus.mem_req, 1);
    reset = 1; core_req = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_busy_req", bus.mem_req, 0);
    chk("rst_busy_wait", wait_cycles, 0);
    chk("rst_busy_rdata", core_rdata, 0);
    chk("rst_busy_err", bus_err, 0);
    reset = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_done) pulses++;
    end
    chk("rst_no_done", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
